// File: rtl/kiwi_abend_waypoint_reporter.sv
// Run-status reporter for generated Kiwi designs: abend syndrome, waypoint text,
// cycle/delta counters, exported PC and unary LEDs for the simulation wrapper.
module kiwi_abend_waypoint_reporter #(
  parameter int NUM_WP   = 8,
  parameter int WP_IDX_W = 3,
  parameter int WP_CHARS = 80,
  parameter int CNT_W    = 32,
  parameter int LED_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wp_valid,
  input  logic [WP_IDX_W-1:0]     wp_index,
  input  logic                    chr_we,
  input  logic [WP_IDX_W-1:0]     chr_slot,
  input  logic [6:0]              chr_pos,
  input  logic [7:0]              chr_data,
  input  logic                    exit_valid,
  input  logic                    abend_valid,
  input  logic [7:0]              abend_code,
  input  logic [31:0]             pc_in,
  output logic [7:0]              hpr_abend_syndrome,
  output logic [8*WP_CHARS-1:0]   KppWaypoint0,
  output logic                    wp_strobe,
  output logic [CNT_W-1:0]        wp_delta,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [31:0]             pc_export,
  output logic [LED_W-1:0]        hpr_unary_leds,
  output logic                    halted
);

  localparam int                SLOT_W     = $clog2(NUM_WP);
  localparam logic [WP_IDX_W:0] NUM_WP_L   = (WP_IDX_W+1)'(NUM_WP);
  localparam logic [7:0]        WP_CHARS_L = 8'(WP_CHARS);

  typedef enum logic {RUN, HALTED} state_e;
  state_e state_q, state_d;

  logic [7:0]            syn_q, syn_d;
  logic [8*WP_CHARS-1:0] text_q, text_d, rd_text;
  logic                  strobe_q, strobe_d;
  logic [CNT_W-1:0]      delta_q, delta_d, cycle_q, cycle_d, last_q, last_d;
  logic [31:0]           pc_q, pc_d;
  logic [LED_W-1:0]      leds_q, leds_d;
  logic [WP_IDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic                  cur_vld_q, cur_vld_d;
  logic                  chr_ok, wp_ok;
  logic [SLOT_W-1:0]     wp_slot, chr_slot_s;

  logic [7:0] store_q [NUM_WP][WP_CHARS];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // 0 and 255 would read as clean exit / still running, so they become 254.
  function automatic logic [7:0] abend_map(input logic [7:0] c);
    return (c == 8'h00 || c == 8'hFF) ? 8'hFE : c;
  endfunction

  function automatic logic [LED_W-1:0] therm(input logic [WP_IDX_W-1:0] idx);
    logic [LED_W-1:0] t;
    for (int i = 0; i < LED_W; i++) t[i] = (i <= int'(idx));
    return t;
  endfunction

  assign wp_slot    = wp_index[SLOT_W-1:0];
  assign chr_slot_s = chr_slot[SLOT_W-1:0];
  assign chr_ok = chr_we && ({1'b0, chr_slot} < NUM_WP_L) && ({1'b0, chr_pos} < WP_CHARS_L);
  assign wp_ok  = wp_valid && ({1'b0, wp_index} < NUM_WP_L) &&
                  (!cur_vld_q || wp_index != cur_idx_q);

  always_ff @(posedge clk) begin
    if (chr_ok) store_q[chr_slot_s][chr_pos] <= chr_data;
  end

  // Write-first read so a char stored in the same cycle is displayed.
  always_comb begin
    rd_text = '0;
    for (int p = 0; p < WP_CHARS; p++)
      rd_text[8*p +: 8] = (chr_ok && chr_slot == wp_index && chr_pos == 7'(p)) ?
                          chr_data : store_q[wp_slot][p];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      syn_q     <= 8'hFF;
      text_q    <= '0;
      strobe_q  <= 1'b0;
      delta_q   <= '0;
      cycle_q   <= '0;
      last_q    <= '0;
      pc_q      <= '0;
      leds_q    <= '0;
      cur_idx_q <= '0;
      cur_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      syn_q     <= syn_d;
      text_q    <= text_d;
      strobe_q  <= strobe_d;
      delta_q   <= delta_d;
      cycle_q   <= cycle_d;
      last_q    <= last_d;
      pc_q      <= pc_d;
      leds_q    <= leds_d;
      cur_idx_q <= cur_idx_d;
      cur_vld_q <= cur_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && (exit_valid || abend_valid)) state_d = HALTED;
  end

  always_comb begin
    syn_d     = syn_q;
    text_d    = text_q;
    strobe_d  = 1'b0;
    delta_d   = delta_q;
    cycle_d   = cycle_q;
    last_d    = last_q;
    pc_d      = pc_q;
    leds_d    = leds_q;
    cur_idx_d = cur_idx_q;
    cur_vld_d = cur_vld_q;
    if (state_q == RUN) begin
      cycle_d = sat_inc(cycle_q);
      pc_d    = pc_in;
      if (wp_ok) begin
        text_d    = rd_text;
        delta_d   = cycle_q - last_q;
        last_d    = cycle_q;
        cur_idx_d = wp_index;
        cur_vld_d = 1'b1;
        strobe_d  = 1'b1;
        leds_d    = therm(wp_index);
      end
      if (abend_valid)     syn_d = abend_map(abend_code);
      else if (exit_valid) syn_d = 8'h00;
    end
  end

  always_comb begin
    halted = (state_q == HALTED);
  end

  assign hpr_abend_syndrome = syn_q;
  assign KppWaypoint0       = text_q;
  assign wp_strobe          = strobe_q;
  assign wp_delta           = delta_q;
  assign cycle_count        = cycle_q;
  assign pc_export          = pc_q;
  assign hpr_unary_leds     = leds_q;

endmodule

// File: tb/tb_kiwi_abend_waypoint_reporter.sv
// Directed bench for kiwi_abend_waypoint_reporter; a 4-bit index lets
// out-of-range slots be driven against the 8-slot store.
module tb_kiwi_abend_waypoint_reporter;
  logic         clk = 1'b0;
  logic         reset, wp_valid, chr_we, exit_valid, abend_valid;
  logic [3:0]   wp_index, chr_slot;
  logic [6:0]   chr_pos;
  logic [7:0]   chr_data, abend_code;
  logic [31:0]  pc_in;
  logic [7:0]   hpr_abend_syndrome;
  logic [639:0] KppWaypoint0;
  logic         wp_strobe, halted;
  logic [31:0]  wp_delta, cycle_count, pc_export;
  logic [7:0]   hpr_unary_leds;

  int tests = 0;
  int fails = 0;
  int pulses;
  logic [39:0] start_str = 40'h5354415254;

  always #5 clk = ~clk;

  kiwi_abend_waypoint_reporter #(
    .NUM_WP(8), .WP_IDX_W(4), .WP_CHARS(80), .CNT_W(32), .LED_W(8)
  ) dut (
    .clk(clk), .reset(reset), .wp_valid(wp_valid), .wp_index(wp_index),
    .chr_we(chr_we), .chr_slot(chr_slot), .chr_pos(chr_pos), .chr_data(chr_data),
    .exit_valid(exit_valid), .abend_valid(abend_valid), .abend_code(abend_code),
    .pc_in(pc_in), .hpr_abend_syndrome(hpr_abend_syndrome),
    .KppWaypoint0(KppWaypoint0), .wp_strobe(wp_strobe), .wp_delta(wp_delta),
    .cycle_count(cycle_count), .pc_export(pc_export),
    .hpr_unary_leds(hpr_unary_leds), .halted(halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    wp_valid = 1'b0; wp_index = '0; chr_we = 1'b0; chr_slot = '0; chr_pos = '0;
    chr_data = '0; exit_valid = 1'b0; abend_valid = 1'b0; abend_code = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_syn"},    640'(hpr_abend_syndrome), 640'(8'hFF));
    check({pfx, "_text"},   KppWaypoint0, 640'(0));
    check({pfx, "_strobe"}, 640'(wp_strobe), 640'(1'b0));
    check({pfx, "_delta"},  640'(wp_delta), 640'(0));
    check({pfx, "_cycle"},  640'(cycle_count), 640'(0));
    check({pfx, "_pc"},     640'(pc_export), 640'(0));
    check({pfx, "_leds"},   640'(hpr_unary_leds), 640'(0));
    check({pfx, "_halted"}, 640'(halted), 640'(1'b0));
  endtask

  initial begin
    clr_inputs();
    pc_in = 32'h1000_0040;
    reset = 1'b1;
    tick();
    check_reset_vals("rst");
    reset = 1'b0;

    pulses = 0;
    repeat (10) begin
      tick();
      if (wp_strobe) pulses++;
    end
    check("idle_cycle",  640'(cycle_count), 640'(10));
    check("idle_syn",    640'(hpr_abend_syndrome), 640'(8'hFF));
    check("idle_text",   KppWaypoint0, 640'(0));
    check("idle_pulses", 640'(pulses), 640'(0));
    check("idle_pc",     640'(pc_export), 640'(32'h1000_0040));

    pulse_reset();
    for (int p = 4; p >= 0; p--) begin
      chr_we = 1'b1; chr_slot = 4'd2; chr_pos = 7'(p); chr_data = start_str[8*p +: 8];
      tick();
    end
    chr_we = 1'b0;
    check("pre_wp2_cycle", 640'(cycle_count), 640'(5));
    wp_valid = 1'b1; wp_index = 4'd2;
    tick();
    wp_valid = 1'b0;
    check("wp2_text",   640'(KppWaypoint0[39:0]), 640'(start_str));
    check("wp2_delta",  640'(wp_delta), 640'(5));
    check("wp2_leds",   640'(hpr_unary_leds), 640'(8'h07));
    check("wp2_strobe", 640'(wp_strobe), 640'(1'b1));
    tick();
    check("wp2_strobe_low", 640'(wp_strobe), 640'(1'b0));

    repeat (5) tick();
    check("pre_wp3_cycle", 640'(cycle_count), 640'(12));
    wp_valid = 1'b1; wp_index = 4'd3;
    tick();
    wp_valid = 1'b0;
    check("wp3_delta",  640'(wp_delta), 640'(7));
    check("wp3_leds",   640'(hpr_unary_leds), 640'(8'h0F));
    check("wp3_strobe", 640'(wp_strobe), 640'(1'b1));
    repeat (2) tick();
    wp_valid = 1'b1; wp_index = 4'd3;
    tick();
    wp_valid = 1'b0;
    check("rep3_strobe", 640'(wp_strobe), 640'(1'b0));
    check("rep3_delta",  640'(wp_delta), 640'(7));

    repeat (4) tick();
    check("pre_halt_cycle", 640'(cycle_count), 640'(20));
    abend_valid = 1'b1; abend_code = 8'h2A; exit_valid = 1'b1;
    wp_valid = 1'b1; wp_index = 4'd5;
    tick();
    abend_valid = 1'b0; wp_index = 4'd6; pc_in = 32'hBEEF_0001;
    check("halt_syn",    640'(hpr_abend_syndrome), 640'(8'h2A));
    check("halt_flag",   640'(halted), 640'(1'b1));
    check("halt_cycle",  640'(cycle_count), 640'(21));
    check("halt_delta",  640'(wp_delta), 640'(8));
    check("halt_leds",   640'(hpr_unary_leds), 640'(8'h3F));
    check("halt_strobe", 640'(wp_strobe), 640'(1'b1));
    repeat (3) tick();
    check("frz_cycle",  640'(cycle_count), 640'(21));
    check("frz_syn",    640'(hpr_abend_syndrome), 640'(8'h2A));
    check("frz_strobe", 640'(wp_strobe), 640'(1'b0));
    check("frz_leds",   640'(hpr_unary_leds), 640'(8'h3F));
    check("frz_pc",     640'(pc_export), 640'(32'h1000_0040));
    check("frz_halted", 640'(halted), 640'(1'b1));
    clr_inputs();

    pulse_reset();
    abend_valid = 1'b1; abend_code = 8'h00;
    tick();
    abend_valid = 1'b0;
    check("abend00_syn",    640'(hpr_abend_syndrome), 640'(8'hFE));
    check("abend00_halted", 640'(halted), 640'(1'b1));
    pulse_reset();
    abend_valid = 1'b1; abend_code = 8'hFF;
    tick();
    abend_valid = 1'b0;
    check("abendFF_syn", 640'(hpr_abend_syndrome), 640'(8'hFE));
    pulse_reset();
    exit_valid = 1'b1;
    tick();
    exit_valid = 1'b0;
    check("exit_syn",    640'(hpr_abend_syndrome), 640'(8'h00));
    check("exit_halted", 640'(halted), 640'(1'b1));

    pulse_reset();
    wp_valid = 1'b1; wp_index = 4'd9;
    chr_we = 1'b1; chr_slot = 4'd10; chr_pos = 7'd0; chr_data = 8'h51;
    tick();
    chr_slot = 4'd2; chr_pos = 7'd90;
    tick();
    clr_inputs();
    check("oor_strobe", 640'(wp_strobe), 640'(1'b0));
    check("oor_leds",   640'(hpr_unary_leds), 640'(0));
    check("oor_delta",  640'(wp_delta), 640'(0));
    check("run_pc",     640'(pc_export), 640'(32'hBEEF_0001));
    chr_we = 1'b1; chr_slot = 4'd1; chr_pos = 7'd0; chr_data = 8'h5A;
    wp_valid = 1'b1; wp_index = 4'd1;
    tick();
    clr_inputs();
    check("wf_char",   640'(KppWaypoint0[7:0]), 640'(8'h5A));
    check("wf_strobe", 640'(wp_strobe), 640'(1'b1));
    check("wf_leds",   640'(hpr_unary_leds), 640'(8'h03));
    check("wf_delta",  640'(wp_delta), 640'(2));
    tick();

    reset = 1'b1; wp_valid = 1'b1; wp_index = 4'd2; exit_valid = 1'b1;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0; exit_valid = 1'b0;
    tick();
    wp_valid = 1'b0;
    check("ret_text",   640'(KppWaypoint0[39:0]), 640'(start_str));
    check("ret_strobe", 640'(wp_strobe), 640'(1'b1));
    check("ret_delta",  640'(wp_delta), 640'(0));
    check("ret_leds",   640'(hpr_unary_leds), 640'(8'h07));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
